// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding and the RV32I NOP used to pad unused memory.
package imem_boot_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic [7:0] nop_byte(input logic [1:0] k);
        return NOP_INSN[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Streams a boot image into byte-wide instruction memory, pads the rest with NOPs,
// then releases the core from reset.
//
// state | meaning
// IDLE  | waiting for a load request, core held in reset
// LOAD  | accepting program bytes, one write per handshake
// PAD   | writing NOP bytes up to the last memory location
// RUN   | image complete, core released, memory read-only
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   MEM_LEN   = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                len_ok;
    logic                hs;
    logic [ADDR_W:0]     addr_next_w;

    assign len_ok      = (len != '0) && (len <= MEM_LEN) && (len[1:0] == 2'b00);
    assign hs          = s_valid && (state_q == ST_LOAD);
    assign addr_next_w = {1'b0, addr_q} + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    if (len_ok) begin
                        err_d   = 1'b0;
                        addr_d  = '0;
                        cnt_d   = len;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // A full-size image has nothing to pad and goes straight to RUN.
                        if (addr_next_w < MEM_LEN) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = nop_byte(addr_q[1:0]);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_PAD);
    assign cpu_rst_n = (state_q == ST_RUN);
    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal, bubbled, full-size, rejected,
// reloaded and reset-interrupted loads checked against a memory-image model.
module tb_imem_boot_loader;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_boot_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] img[MEM_BYTES];
    int         wr_cyc[MEM_BYTES];
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] prog[MEM_BYTES];
    int         c_start = 0;
    int         done_rel = 0;
    logic       busy1, rst1, err1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            img[mem_addr]    = mem_wdata;
            wr_cyc[mem_addr] = cyc;
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] exp_byte(input int a, input int n);
        if (a < n) return prog[a];
        return (a % 4 == 0) ? 8'h13 : 8'h00;
    endfunction

    task automatic check_image(input string tag, input int n);
        for (int a = 0; a < MEM_BYTES; a++)
            check_val($sformatf("%s[%0d]", tag, a), {24'b0, img[a]}, {24'b0, exp_byte(a, n)});
    endtask

    // Cycle 0 carries start; cycle k is the k-th cycle after the sampling edge.
    task automatic run_load(input int n, input bit bubble, input bit glitch);
        int idx;
        int guard;
        @(posedge clk);
        #1;
        for (int a = 0; a < MEM_BYTES; a++) begin
            img[a]    = 8'hAA;
            wr_cyc[a] = -1;
        end
        wr_cnt = 0;
        done_cnt = 0;
        done_rel = -1;
        @(negedge clk);
        c_start = cyc;
        start = 1'b1;
        len = n[ADDR_W:0];
        idx = 0;
        for (int t = 0; t < 300 && idx < n; t++) begin
            @(negedge clk);
            if (t == 0) begin
                busy1 = busy;
                rst1  = cpu_rst_n;
                err1  = err;
            end
            if (glitch && t == 2) begin
                start = 1'b1;
                len   = 7'd3;
            end else begin
                start = 1'b0;
            end
            s_valid = bubble ? (t % 2 == 1) : 1'b1;
            s_data  = prog[idx];
            if (s_valid && s_ready) idx++;
        end
        check_val("stream_len", idx, n);
        guard = 0;
        @(negedge clk);
        s_valid = 1'b0;
        start = 1'b0;
        while (done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("done_seen", {31'b0, done}, 1);
        done_rel = cyc - c_start;
        repeat (3) @(negedge clk);
    endtask

    task automatic reject(input int n, input string tag, input logic exp_run);
        int wr0;
        @(negedge clk);
        wr0 = wr_cnt;
        start = 1'b1;
        len = n[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_err"}, {31'b0, err}, 1);
        check_val({tag, "_busy"}, {31'b0, busy}, 0);
        check_val({tag, "_ready"}, {31'b0, s_ready}, 0);
        check_val({tag, "_rstn"}, {31'b0, cpu_rst_n}, {31'b0, exp_run});
        @(negedge clk);
        check_val({tag, "_nowrite"}, wr_cnt, wr0);
    endtask

    initial begin
        logic [7:0] boot[8];
        boot = '{8'h33, 8'h83, 8'h49, 8'h01, 8'h13, 8'h03, 8'he3, 8'hff};
        for (int a = 0; a < MEM_BYTES; a++) prog[a] = 8'(a * 7 + 5);
        for (int a = 0; a < 8; a++) prog[a] = boot[a];

        repeat (3) @(negedge clk);
        check_val("rst_s_ready", {31'b0, s_ready}, 0);
        check_val("rst_mem_we", {31'b0, mem_we}, 0);
        check_val("rst_mem_addr", {26'b0, mem_addr}, 0);
        check_val("rst_mem_wdata", {24'b0, mem_wdata}, 0);
        check_val("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_done", {31'b0, done}, 0);
        check_val("rst_err", {31'b0, err}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Normal load, len=8
        run_load(8, 1'b0, 1'b0);
        check_val("norm_busy1", {31'b0, busy1}, 1);
        check_val("norm_rstn1", {31'b0, rst1}, 0);
        check_val("norm_done_cyc", done_rel, 65);
        check_val("norm_wr_cnt", wr_cnt, 64);
        check_val("norm_done_cnt", done_cnt, 1);
        for (int k = 0; k < 8; k++)
            check_val($sformatf("norm_wcyc%0d", k), wr_cyc[k], c_start + k + 2);
        check_val("norm_wcyc8", wr_cyc[8], c_start + 10);
        check_val("norm_wcyc63", wr_cyc[63], c_start + 65);
        check_image("norm_img", 8);
        check_val("norm_run_rstn", {31'b0, cpu_rst_n}, 1);
        check_val("norm_run_busy", {31'b0, busy}, 0);
        check_val("norm_run_we", {31'b0, mem_we}, 0);

        // Bubbled load: valid only on even cycles after start
        run_load(8, 1'b1, 1'b0);
        check_val("bub_done_cyc", done_rel, 73);
        check_val("bub_wr_cnt", wr_cnt, 64);
        for (int k = 0; k < 8; k++)
            check_val($sformatf("bub_wcyc%0d", k), wr_cyc[k], c_start + 2 * k + 3);
        check_val("bub_wcyc8", wr_cyc[8], c_start + 18);
        check_image("bub_img", 8);

        // Full image, with an ignored bad start in mid-load
        run_load(64, 1'b0, 1'b1);
        check_val("full_done_cyc", done_rel, 65);
        check_val("full_wcyc63", wr_cyc[63], c_start + 65);
        check_val("full_wr_cnt", wr_cnt, 64);
        check_val("full_done_cnt", done_cnt, 1);
        check_val("full_err", {31'b0, err}, 0);
        check_image("full_img", 64);

        // Rejections from IDLE
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reject(6, "rej6", 1'b0);
        reject(0, "rej0", 1'b0);
        reject(68, "rej68", 1'b0);
        run_load(4, 1'b0, 1'b0);
        check_val("acc4_err1", {31'b0, err1}, 0);
        check_val("acc4_done_cyc", done_rel, 65);
        check_image("acc4_img", 4);

        // Rejection in RUN keeps the core running, then reload from RUN
        reject(5, "rej_run", 1'b1);
        run_load(4, 1'b0, 1'b0);
        check_val("reld_rstn1", {31'b0, rst1}, 0);
        check_val("reld_err1", {31'b0, err1}, 0);
        check_val("reld_wr_cnt", wr_cnt, 64);
        check_val("reld_done_cnt", done_cnt, 1);
        check_val("reld_done_cyc", done_rel, 65);
        check_val("reld_wcyc4", wr_cyc[4], c_start + 6);
        check_image("reld_img", 4);

        // Reset after three handshakes
        @(negedge clk);
        start = 1'b1;
        len = 7'd8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            s_valid = 1'b1;
            s_data = prog[k];
        end
        @(posedge clk);
        #2;
        check_val("mid_pre_we", {31'b0, mem_we}, 1);
        check_val("mid_pre_addr", {26'b0, mem_addr}, 2);
        reset = 1'b0;
        s_valid = 1'b0;
        #1;
        check_val("mid_s_ready", {31'b0, s_ready}, 0);
        check_val("mid_mem_we", {31'b0, mem_we}, 0);
        check_val("mid_mem_addr", {26'b0, mem_addr}, 0);
        check_val("mid_mem_wdata", {24'b0, mem_wdata}, 0);
        check_val("mid_cpu_rst_n", {31'b0, cpu_rst_n}, 0);
        check_val("mid_busy", {31'b0, busy}, 0);
        check_val("mid_done", {31'b0, done}, 0);
        check_val("mid_err", {31'b0, err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b1;
        #1;
        wr_cnt = 0;
        repeat (5) @(negedge clk);
        check_val("mid_after_wr", wr_cnt, 0);
        check_val("mid_after_busy", {31'b0, busy}, 0);
        check_val("mid_after_ready", {31'b0, s_ready}, 0);
        check_val("mid_after_rstn", {31'b0, cpu_rst_n}, 0);
        s_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
